// File: rtl/cppf_link_pkg.sv
// CPPF link word-level definitions shared by
// the CRC inserter and the receive checker.
package cppf_link_pkg;

  localparam logic [3:0] K_PAD = 4'b1111;
  localparam logic [3:0] K_COMMA = 4'b0001;
  localparam logic [3:0] K_NONE = 4'b0000;

  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;

  typedef enum logic [2:0] {
    W_PAD,
    W_DATA,
    W_TRAIL,
    W_RSYNC,
    W_COMMA
  } word_t;

  typedef enum logic [1:0] {
    S_HUNT,
    S_ARMED,
    S_ACTIVE
  } state_t;

  // MSB-first CRC-32 over one word, no reflection
  function automatic logic [31:0] crc32_word(
    input logic [31:0] c,
    input logic [31:0] w
  );
    logic [31:0] r;
    logic fb;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      fb = r[31] ^ w[i];
      r = {r[30:0], 1'b0} ^ ({32{fb}} & CRC_POLY);
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_crc_if.sv
// Receive-side link bus: raw words in,
// delayed words plus CRC status out.
interface rx_crc_if #(
  parameter int CNT_W = 16
);

  logic [31:0] d;
  logic [3:0] k;
  logic cnt_clr;

  logic [31:0] dout;
  logic [3:0] kout;
  logic crc_slot;
  logic crc_ok;
  logic crc_err;
  logic err_sticky;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic locked;

  modport master (
    output d, k, cnt_clr,
    input dout, kout, crc_slot,
    input crc_ok, crc_err, err_sticky,
    input frame_cnt, err_cnt, locked
  );

  modport slave (
    input d, k, cnt_clr,
    output dout, kout, crc_slot,
    output crc_ok, crc_err, err_sticky,
    output frame_cnt, err_cnt, locked
  );

endinterface

// File: rtl/crc_ol.sv
// Word-wide CRC-32 accumulator with
// synchronous clear.
module crc_ol
  import cppf_link_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        crc_en,
  input  logic [31:0] data_in,
  output logic [31:0] crc_out
);

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_out <= '0;
    end else if (crc_en) begin
      crc_out <= crc32_word(crc_out, data_in);
    end
  end

endmodule

// File: rtl/rx_crc.sv
// CPPF receive CRC checker: decodes the K
// sequence, checks trailers, counts frames.
module rx_crc
  import cppf_link_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  rx_crc_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] SAT = '1;

  word_t cls;
  state_t state;

  logic kr;
  logic krr;
  logic crc_clr;
  logic crc_en;
  logic [31:0] crc_val;
  logic chk;
  logic match;

  logic [31:0] dout_q;
  logic [3:0] kout_q;
  logic slot_q;
  logic ok_q;
  logic err_q;
  logic sticky_q;
  logic [CNT_W-1:0] frame_q;
  logic [CNT_W-1:0] errc_q;

  always_comb begin
    cls = W_COMMA;
    unique case (1'b1)
      (bus.k == K_PAD):
        cls = W_PAD;
      (bus.k == K_NONE && kr && !krr):
        cls = W_TRAIL;
      (bus.k == K_NONE && !(kr && !krr)):
        cls = W_DATA;
      (bus.k == K_COMMA && kr && krr):
        cls = W_RSYNC;
      default:
        cls = W_COMMA;
    endcase
  end

  assign crc_en = (cls == W_DATA);
  assign crc_clr = (cls == W_RSYNC);

  crc_ol u_crc (
    .clk     (clk),
    .rst     (crc_clr),
    .crc_en  (crc_en),
    .data_in (bus.d),
    .crc_out (crc_val)
  );

  // Trailers are only trusted once an RSYNC has set up the engine
  assign chk = (cls == W_TRAIL) && (state != S_HUNT);
  assign match = (bus.d == crc_val);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kr <= 1'b0;
      krr <= 1'b0;
      state <= S_HUNT;
    end else if (cls != W_PAD) begin
      kr <= bus.k[0];
      krr <= kr;
      unique case (state)
        S_HUNT: begin
          if (cls == W_RSYNC) state <= S_ARMED;
        end
        S_ARMED: begin
          if (cls == W_DATA) state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (cls == W_TRAIL || cls == W_RSYNC)
            state <= S_ARMED;
        end
        default: state <= S_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      kout_q <= '0;
      slot_q <= 1'b0;
      ok_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      dout_q <= bus.d;
      kout_q <= bus.k;
      slot_q <= chk;
      ok_q <= chk && match;
      err_q <= chk && !match;
    end
  end

  // Clear beats a same-cycle compare for counters and sticky
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      errc_q <= '0;
      sticky_q <= 1'b0;
    end else if (bus.cnt_clr) begin
      frame_q <= '0;
      errc_q <= '0;
      sticky_q <= 1'b0;
    end else if (chk) begin
      if (frame_q != SAT) frame_q <= frame_q + ONE;
      if (!match) begin
        sticky_q <= 1'b1;
        if (errc_q != SAT) errc_q <= errc_q + ONE;
      end
    end
  end

  assign bus.dout = dout_q;
  assign bus.kout = kout_q;
  assign bus.crc_slot = slot_q;
  assign bus.crc_ok = ok_q;
  assign bus.crc_err = err_q;
  assign bus.err_sticky = sticky_q;
  assign bus.frame_cnt = frame_q;
  assign bus.err_cnt = errc_q;
  assign bus.locked = (state != S_HUNT);

endmodule

// File: tb/tb_rx_crc.sv
// Directed bench for rx_crc: loopback, corruption,
// padding, lock, saturation and reset cases.
module tb_rx_crc;

  logic clk;
  logic rst;

  rx_crc_if #(.CNT_W(4)) bus ();

  rx_crc #(.CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total;
  int bad;

  int n_ok;
  int n_err;
  int n_slot;
  int pad_slot;
  logic t_ok;
  logic t_err;
  logic t_slot;
  logic [31:0] t_dout;
  logic [31:0] c_dout;
  logic [31:0] exp_crc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference CRC: xor the word in, then 32 polynomial shifts
  function automatic logic [31:0] crc_next(
    input logic [31:0] c,
    input logic [31:0] w
  );
    logic [31:0] r;
    r = c ^ w;
    for (int b = 0; b < 32; b++)
      r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
    return r;
  endfunction

  task automatic put(input logic [31:0] w, input logic [3:0] kk);
    bus.d = w;
    bus.k = kk;
    @(posedge clk);
    #1;
    if (bus.crc_ok) n_ok++;
    if (bus.crc_err) n_err++;
    if (bus.crc_slot) n_slot++;
    if (kk == 4'hF && bus.crc_slot) pad_slot++;
  endtask

  task automatic pad_if(input bit p);
    if (p) put(32'h0000_0000, 4'hF);
  endtask

  task automatic clear_stats();
    n_ok = 0;
    n_err = 0;
    n_slot = 0;
    pad_slot = 0;
  endtask

  task automatic send_frame(
    input int corrupt,
    input bit pad,
    input bit bad_tr,
    input bit clr
  );
    logic [31:0] c;
    logic [31:0] w;
    clear_stats();
    c = '0;
    repeat (3) begin
      put(32'h0000_00BC, 4'b0001);
      pad_if(pad);
    end
    for (int i = 1; i <= 10; i++) begin
      c = crc_next(c, 32'(i));
      w = 32'(i);
      if (i == corrupt) w = w ^ 32'h0000_0020;
      put(w, 4'b0000);
      if (i == corrupt) c_dout = bus.dout;
      pad_if(pad);
    end
    put(32'h0000_00BC, 4'b0001);
    pad_if(pad);
    exp_crc = c;
    bus.cnt_clr = clr;
    put(c ^ {31'b0, bad_tr}, 4'b0000);
    bus.cnt_clr = 1'b0;
    t_ok = bus.crc_ok;
    t_err = bus.crc_err;
    t_slot = bus.crc_slot;
    t_dout = bus.dout;
    pad_if(pad);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.d = 32'hDEAD_BEEF;
    bus.k = 4'b0000;
    bus.cnt_clr = 1'b0;
    rst = 1'b1;
    #12;
    total++;
    if (bus.dout !== 32'h0) begin
      bad++;
      $display("FAIL reset_dout got=%h want=0", bus.dout);
    end
    total++;
    if ({bus.kout, bus.crc_slot, bus.crc_ok, bus.crc_err} !== 7'h0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0",
        {bus.kout, bus.crc_slot, bus.crc_ok, bus.crc_err});
    end
    total++;
    if ({bus.frame_cnt, bus.err_cnt, bus.err_sticky, bus.locked} !== 10'h0) begin
      bad++;
      $display("FAIL reset_status got=%h want=0",
        {bus.frame_cnt, bus.err_cnt, bus.err_sticky, bus.locked});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_loopback();
    send_frame(0, 1'b0, 1'b0, 1'b0);
    total++;
    if ({t_ok, t_err, t_slot} !== 3'b101) begin
      bad++;
      $display("FAIL loop_pulse got=%b want=101", {t_ok, t_err, t_slot});
    end
    total++;
    if (t_dout !== exp_crc) begin
      bad++;
      $display("FAIL loop_dout got=%h want=%h", t_dout, exp_crc);
    end
    total++;
    if (bus.frame_cnt !== 4'd1 || bus.err_cnt !== 4'd0) begin
      bad++;
      $display("FAIL loop_cnt got=%0d/%0d want=1/0",
        bus.frame_cnt, bus.err_cnt);
    end
    total++;
    if (bus.locked !== 1'b1 || n_slot != 1) begin
      bad++;
      $display("FAIL loop_lock got=%b/%0d want=1/1", bus.locked, n_slot);
    end
  endtask

  task automatic test_corrupt();
    send_frame(4, 1'b0, 1'b0, 1'b0);
    total++;
    if ({t_ok, t_err} !== 2'b01) begin
      bad++;
      $display("FAIL bad_pulse got=%b want=01", {t_ok, t_err});
    end
    total++;
    if (bus.err_cnt !== 4'd1 || bus.frame_cnt !== 4'd2) begin
      bad++;
      $display("FAIL bad_cnt got=%0d/%0d want=1/2",
        bus.err_cnt, bus.frame_cnt);
    end
    total++;
    if (bus.err_sticky !== 1'b1) begin
      bad++;
      $display("FAIL bad_sticky got=%b want=1", bus.err_sticky);
    end
    total++;
    if (c_dout !== 32'h0000_0024) begin
      bad++;
      $display("FAIL bad_dout got=%h want=00000024", c_dout);
    end
  endtask

  task automatic test_padding();
    send_frame(0, 1'b1, 1'b0, 1'b0);
    total++;
    if ({t_ok, t_err, n_slot} !== {2'b10, 32'd1}) begin
      bad++;
      $display("FAIL pad_result got=%b%b slots=%0d want=10 slots=1",
        t_ok, t_err, n_slot);
    end
    total++;
    if (pad_slot != 0) begin
      bad++;
      $display("FAIL pad_slot got=%0d want=0", pad_slot);
    end
    total++;
    if (bus.frame_cnt !== 4'd3) begin
      bad++;
      $display("FAIL pad_cnt got=%0d want=3", bus.frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] c;
    send_frame(0, 1'b0, 1'b0, 1'b0);
    c = exp_crc;
    clear_stats();
    for (int i = 17; i <= 19; i++) begin
      c = crc_next(c, 32'(i));
      put(32'(i), 4'b0000);
    end
    put(32'h0000_00BC, 4'b0001);
    put(c, 4'b0000);
    total++;
    if ({bus.crc_ok, bus.crc_err} !== 2'b10) begin
      bad++;
      $display("FAIL b2b_pulse got=%b want=10", {bus.crc_ok, bus.crc_err});
    end
    total++;
    if (bus.frame_cnt !== 4'd5 || bus.err_cnt !== 4'd1) begin
      bad++;
      $display("FAIL b2b_cnt got=%0d/%0d want=5/1",
        bus.frame_cnt, bus.err_cnt);
    end
  endtask

  task automatic test_out_of_lock();
    do_reset();
    clear_stats();
    put(32'h0000_0005, 4'b0000);
    put(32'h0000_00BC, 4'b0001);
    put(32'h1234_5678, 4'b0000);
    total++;
    if (bus.dout !== 32'h1234_5678) begin
      bad++;
      $display("FAIL lock_dout got=%h want=12345678", bus.dout);
    end
    total++;
    if (bus.locked !== 1'b0 || n_ok != 0 || n_err != 0 || n_slot != 0) begin
      bad++;
      $display("FAIL lock_quiet got=%b ok=%0d err=%0d slot=%0d want=0",
        bus.locked, n_ok, n_err, n_slot);
    end
    total++;
    if (bus.frame_cnt !== 4'd0 || bus.err_cnt !== 4'd0) begin
      bad++;
      $display("FAIL lock_cnt got=%0d/%0d want=0/0",
        bus.frame_cnt, bus.err_cnt);
    end
  endtask

  task automatic test_saturation();
    int errs;
    errs = 0;
    for (int f = 0; f < 20; f++) begin
      send_frame(0, 1'b0, 1'b1, 1'b0);
      errs += n_err;
    end
    total++;
    if (errs != 20) begin
      bad++;
      $display("FAIL sat_pulses got=%0d want=20", errs);
    end
    total++;
    if (bus.err_cnt !== 4'd15 || bus.frame_cnt !== 4'd15) begin
      bad++;
      $display("FAIL sat_cnt got=%0d/%0d want=15/15",
        bus.err_cnt, bus.frame_cnt);
    end
    send_frame(0, 1'b0, 1'b1, 1'b1);
    total++;
    if (t_err !== 1'b1) begin
      bad++;
      $display("FAIL clr_pulse got=%b want=1", t_err);
    end
    total++;
    if ({bus.err_cnt, bus.frame_cnt, bus.err_sticky} !== 9'h0) begin
      bad++;
      $display("FAIL clr_state got=%0d/%0d/%b want=0/0/0",
        bus.err_cnt, bus.frame_cnt, bus.err_sticky);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] c;
    send_frame(0, 1'b0, 1'b0, 1'b0);
    repeat (3) put(32'h0000_00BC, 4'b0001);
    for (int i = 1; i <= 4; i++) put(32'(i), 4'b0000);
    rst = 1'b1;
    #1;
    total++;
    if (bus.dout !== 32'h0 || bus.kout !== 4'h0) begin
      bad++;
      $display("FAIL mid_dout got=%h/%h want=0/0", bus.dout, bus.kout);
    end
    total++;
    if ({bus.frame_cnt, bus.locked, bus.crc_slot} !== 6'h0) begin
      bad++;
      $display("FAIL mid_state got=%0d/%b/%b want=0/0/0",
        bus.frame_cnt, bus.locked, bus.crc_slot);
    end
    #2;
    rst = 1'b0;
    clear_stats();
    c = '0;
    for (int i = 1; i <= 10; i++) c = crc_next(c, 32'(i));
    for (int i = 5; i <= 10; i++) put(32'(i), 4'b0000);
    put(32'h0000_00BC, 4'b0001);
    put(c, 4'b0000);
    total++;
    if (n_ok != 0 || n_err != 0 || bus.frame_cnt !== 4'd0) begin
      bad++;
      $display("FAIL mid_nochk got=%0d/%0d/%0d want=0/0/0",
        n_ok, n_err, bus.frame_cnt);
    end
    send_frame(0, 1'b0, 1'b0, 1'b0);
    total++;
    if (t_ok !== 1'b1 || bus.frame_cnt !== 4'd1) begin
      bad++;
      $display("FAIL mid_recover got=%b/%0d want=1/1", t_ok, bus.frame_cnt);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    bus.d = '0;
    bus.k = '0;
    bus.cnt_clr = 1'b0;
    test_reset();
    test_loopback();
    test_corrupt();
    test_padding();
    test_back_to_back();
    test_out_of_lock();
    test_saturation();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
